// File: rtl/lagarto0_pkg.sv
// Shared lagarto0 core definitions: register-file sequencer states and default sizes.
package lagarto0_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

endpackage

// File: rtl/gpr_rdport.sv
// One combinational read port of the GPR bank: storage mux, x0 mask, clear mask and,
// when GPR_BYPASS_EN is defined, write-first bypass from the write port.
module gpr_rdport
    import lagarto0_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = NREG_DEF,
    parameter int AW   = $clog2(NREG)
) (
    input  logic [XLEN-1:0] regs [NREG],
    input  logic [AW-1:0]   rs,
    input  rf_state_e       state,
`ifdef GPR_BYPASS_EN
    input  logic            byp_we,
    input  logic [AW-1:0]   byp_idx,
    input  logic [XLEN-1:0] byp_data,
`endif
    output logic [XLEN-1:0] data
);

    // NOTE: the default assignment first guarantees every path drives data, so no latch is inferred.
    always_comb begin
        data = '0;
        // x0 and the clear sweep mask everything, including the bypass.
        if (state == RF_RUN && rs != '0) begin
            data = regs[rs];
`ifdef GPR_BYPASS_EN
            if (byp_we && byp_idx == rs) begin
                data = byp_data;
            end
`endif
        end
    end

endmodule

// File: rtl/gpr_bank.sv
// Parametrised lagarto0 GPR bank: x0 hardwired to zero, hardware clear after reset.
// Optional write-to-read bypass selected by the GPR_BYPASS_EN macro.
module gpr_bank
    import lagarto0_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [AW-1:0]       rd_i,
    input  logic [XLEN-1:0]     datord_i,
    input  logic                wren_i,
    input  logic [NRD*AW-1:0]   rs_i,
    output logic [NRD*XLEN-1:0] dators_o,
    output logic                ready_o
);

    logic [XLEN-1:0] regs [NREG];

    rf_state_e     state_q, state_d;
    logic [AW-1:0] clr_idx_q, clr_idx_d;
    logic          clr_we;
    logic          run_we;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        clr_we    = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we    = 1'b1;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == AW'(NREG - 1)) begin
                    state_d = RF_RUN;
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RF_CLEAR;
            clr_idx_q <= AW'(1);
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    assign run_we  = (state_q == RF_RUN) && wren_i && (rd_i != '0);
    assign ready_o = (state_q == RF_RUN);

    // NOTE: the array has no reset branch so it maps to plain storage; the clear sweep zeroes it instead.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (clr_we) begin
                regs[clr_idx_q] <= '0;
            end else if (run_we) begin
                regs[rd_i] <= datord_i;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rdport
        gpr_rdport #(
            .XLEN(XLEN),
            .NREG(NREG),
            .AW  (AW)
        ) u_rdport (
            .regs    (regs),
            .rs      (rs_i[k*AW +: AW]),
            .state   (state_q),
`ifdef GPR_BYPASS_EN
            .byp_we  (run_we),
            .byp_idx (rd_i),
            .byp_data(datord_i),
`endif
            .data    (dators_o[k*XLEN +: XLEN])
        );
    end

endmodule

// File: doc/gpr_bank.md
# gpr_bank

Parametrised general-purpose register bank for the lagarto0 core: configurable data width, register count and number of read ports, with x0 hardwired to zero. After reset, a hardware clear sequencer zeroes every register and holds `ready_o` low until the bank is valid. An optional write-to-read bypass makes a same-cycle write visible on the read ports. It sits between decode (read ports) and writeback (write port), replacing the fixed 32×32, two-read-port bank.

## Interface
- `XLEN`, 32, register width in bits.
- `NREG`, 32, number of registers; power of two, 2..64.
- `NRD`, 2, number of read ports, 1..4.
- `AW`, derived `$clog2(NREG)`, register index width; must not be overridden.

Ports:
- `clk_i`  in  1  single clock; all state changes on its rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `rd_i`  in  AW  write index.
- `datord_i`  in  XLEN  write data.
- `wren_i`  in  1  write enable.
- `rs_i`  in  NRD×AW  read indices, packed; port k occupies bits [k*AW +: AW].
- `dators_o`  out  NRD×XLEN  read data, packed the same way as `rs_i`.
- `ready_o`  out  1  bank valid; writes are accepted and reads are real only when high.

## Operation
- The state machine has two states, `RF_CLEAR` and `RF_RUN`.
- **Reset:** a rising edge with `rst_i`=1 sets state=`RF_CLEAR` and clear index=1. Storage is not written on that edge.
- **RF_CLEAR:**
  - Each edge with `rst_i`=0 writes 0 to GPR[idx] and increments idx.
  - On the edge that clears index NREG-1, state moves to `RF_RUN`.
  - `wren_i` is ignored, so external writes are dropped.
  - All `dators_o` are forced to 0.
  - `ready_o`=0.
- **RF_RUN:**
  - `ready_o`=1.
  - A write occurs on an edge when `wren_i`=1 and `rd_i`≠0. Writes to index 0 are discarded.
  - Read port k returns 0 when `rs_i[k]`=0, otherwise GPR[`rs_i[k]`].
- **Reads:** combinational with no latency. Any number of ports may read the same index.
- **Reset mid-clear or mid-run:** reset restarts the sweep from index 1. Contents are not preserved.
- **Register 0:** has no storage requirement; the x0 read mask alone guarantees it reads 0.

## Timing
- **During reset:** `ready_o`=0 and all `dators_o`=0.
- **Clear duration:** exactly NREG-1 rising edges with `rst_i`=0 after the last reset edge. `ready_o` rises after the (NREG-1)th such edge, which is 31 cycles for NREG=32.
- **Write latency:** a write on edge N is visible on read ports in cycle N+1 without bypass.
- **Simultaneous write and read of the same nonzero index in RF_RUN:** behaviour is set by `GPR_BYPASS_EN`; see Configuration.
- **Write to index 0 together with a read of index 0:** the read returns 0 in every configuration.

## Configuration
- Macro: `GPR_BYPASS_EN`.
- **Defined:** in RF_RUN, when `wren_i`=1, `rd_i`≠0 and `rs_i[k]`=`rd_i`, port k returns `datord_i` in the same cycle (write-first). This bypass is a combinational path from `datord_i` to `dators_o`.
- **Undefined:** port k returns the stored, pre-write value in that cycle (read-first). There is no combinational path from the write port to the read ports.
- In both configurations, x0 masking and RF_CLEAR forcing take priority over bypass.

## Structure
- **Shared package `lagarto0_pkg`:**
  - Enum `rf_state_e {RF_CLEAR, RF_RUN}`.
  - Constant `XLEN_DEF`=32.
  - Constant `NREG_DEF`=32.
- **Sub-module `gpr_rdport`:**
  - Handles one read port: storage mux, x0 mask, clear-state mask and optional bypass.
  - Instantiated NRD times through a generate loop.
- **Top level:** owns the storage array, write logic and the clear FSM/counter.

## Test plan
- **Reset/clear:** NREG=32, hold `rst_i`=1 for 3 cycles, then release.
  - `ready_o`=0 for exactly 31 edges, then 1.
  - Reading all 32 indices then returns 0x00000000.
- **Basic write/read:** in RF_RUN, write 0xDEADBEEF to x5 on one edge.
  - On the next cycle, `rs_i[0]`=5 and `rs_i[1]`=5 both return 0xDEADBEEF.
- **x0 protection:** write 0xFFFFFFFF to x0.
  - Reading x0 returns 0.
  - A neighbouring register, written earlier with 0x12345678, is unchanged.
- **Collision:** x7 holds 0x11111111; write 0x22222222 to x7 while reading x7 in the same cycle.
  - Returns 0x22222222 with `GPR_BYPASS_EN` defined.
  - Returns 0x11111111 without it.
  - Returns 0x22222222 in the next cycle in both configurations.
- **Write during clear:** assert `wren_i`, `rd_i`=3, `datord_i`=0xAAAA5555 while `ready_o`=0.
  - After `ready_o` rises, x3 reads 0.
- **Reset mid-run and generics:** fill x1..x31, then pulse `rst_i` for 1 cycle.
  - Clear repeats (31 cycles) and all registers read 0.
  - Rerun the suite with XLEN=64, NREG=16, NRD=3; clear then takes 15 cycles.
